// File: rtl/kernel_pkg.sv
// Shared constants and the loader/store state type for the kernel coefficient path.
package kernel_pkg;

    localparam int KER_SIZE = 3;
    localparam int DATA_W   = 8;
    localparam int N_COEF   = KER_SIZE * KER_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } kl_state_t;

endpackage

// File: rtl/kernel_bank.sv
// N_COEF x DATA_W coefficient register array with one indexed write port,
// a whole-bank parallel load and a flat read bus.
module kernel_bank #(
    parameter int N_COEF = 9,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           widx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       ld_en_i,
    input  logic [N_COEF*DATA_W-1:0]   ld_data_i,
    output logic [N_COEF*DATA_W-1:0]   rd_flat_o
);

    logic [DATA_W-1:0] mem_q [N_COEF];

    // Parallel load wins over the single-coefficient write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_COEF; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_COEF; i++) begin
                if (ld_en_i) begin
                    mem_q[i] <= ld_data_i[i*DATA_W +: DATA_W];
                end else if (we_i && (widx_i == IDX_W'(i))) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        rd_flat_o = '0;
        for (int i = 0; i < N_COEF; i++) begin
            rd_flat_o[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/kernel_loader.sv
// Streams signed coefficients into a KER_SIZE x KER_SIZE bank with framing checks.
// Define KERNEL_LOADER_DBUF_EN to double-buffer the bank (shadow load, atomic commit).
module kernel_loader #(
    parameter int KER_SIZE = kernel_pkg::KER_SIZE,
    parameter int DATA_W   = kernel_pkg::DATA_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_start,
    input  logic                                s_valid,
    input  logic signed [DATA_W-1:0]            s_data,
    input  logic                                s_last,
    output logic                                s_ready,
    output logic [KER_SIZE*KER_SIZE*DATA_W-1:0] kernel_flat,
    output logic                                kernel_valid,
    output logic                                load_done,
    output logic                                load_err
);

    import kernel_pkg::*;

    localparam int NC       = KER_SIZE * KER_SIZE;
    localparam int IDX_W    = (NC > 1) ? $clog2(NC) : 1;
    localparam int FLAT_W   = NC * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NC - 1);

    kl_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             kv_q, kv_d;

    logic beat_ok;
    logic at_last;
    logic commit;
    logic frame_err;

    // A restart in the same cycle swallows the beat.
    assign beat_ok   = s_valid && (state_q == LOAD) && !load_start;
    assign at_last   = (idx_q == LAST_IDX);
    assign commit    = beat_ok && at_last && s_last;
    assign frame_err = beat_ok && (at_last ^ s_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            kv_q    <= kv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = err_q;
        kv_d    = kv_q;
        if (load_start) begin
            state_d = LOAD;
            idx_d   = '0;
            err_d   = 1'b0;
`ifndef KERNEL_LOADER_DBUF_EN
            kv_d    = 1'b0;
`endif
        end else if (beat_ok) begin
            if (commit) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
                kv_d    = 1'b1;
            end else if (frame_err) begin
                state_d = IDLE;
                idx_d   = '0;
                err_d   = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

`ifdef KERNEL_LOADER_DBUF_EN
    logic [FLAT_W-1:0] shadow_flat;
    logic [FLAT_W-1:0] commit_data;

    kernel_bank #(
        .N_COEF (NC),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_shadow (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (beat_ok),
        .widx_i    (idx_q),
        .wdata_i   (s_data),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_flat_o (shadow_flat)
    );

    // The final beat lands in the shadow on the same edge as the copy, so merge it here.
    always_comb begin
        commit_data = shadow_flat;
        commit_data[(NC-1)*DATA_W +: DATA_W] = s_data;
    end

    kernel_bank #(
        .N_COEF (NC),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_active (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (1'b0),
        .widx_i    ('0),
        .wdata_i   ('0),
        .ld_en_i   (commit),
        .ld_data_i (commit_data),
        .rd_flat_o (kernel_flat)
    );
`else
    kernel_bank #(
        .N_COEF (NC),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_active (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (beat_ok),
        .widx_i    (idx_q),
        .wdata_i   (s_data),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_flat_o (kernel_flat)
    );
`endif

    assign s_ready      = (state_q == LOAD);
    assign kernel_valid = kv_q;
    assign load_done    = done_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Scoreboard bench for kernel_loader: committed kernels are queued as stimulus is driven
// and popped when load_done is seen.
module tb_kernel_loader;

    localparam int KS = 3;
    localparam int DW = 8;
    localparam int NC = KS * KS;
    localparam int FW = NC * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [FW-1:0] kernel_flat;
    logic          kernel_valid;
    logic          load_done;
    logic          load_err;

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] prev_k = '0;

    always #5 clk = ~clk;

    kernel_loader #(
        .KER_SIZE (KS),
        .DATA_W   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .kernel_flat  (kernel_flat),
        .kernel_valid (kernel_valid),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_kernel(input logic [DW-1:0] base);
        logic [FW-1:0] e;
        e = '0;
        for (int i = 0; i < NC; i++) e[i*DW +: DW] = base + DW'(i);
        sb_q.push_back(e);
        for (int i = 0; i < NC; i++) beat(base + DW'(i), i == NC - 1);
    endtask

    task automatic test_reset();
        logic [FW-1:0] exp;
        rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (2) tick();
        total++; if (kernel_flat !== '0) begin bad++; $display("FAIL rst_flat got=%h want=0", kernel_flat); end
        total++; if ({kernel_valid, load_done, load_err, s_ready} !== 4'b0000) begin
            bad++; $display("FAIL rst_flags got=%b want=0000", {kernel_valid, load_done, load_err, s_ready}); end
        rst = 1'b0;
        tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", s_ready); end
        pulse_start();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_start got=%b want=1", s_ready); end
        send_kernel(8'h01);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL first_done got=%b want=1", load_done); end
        total++; if (kernel_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", kernel_valid); end
        total++; if (kernel_flat[7:0] !== 8'h01) begin bad++; $display("FAIL coef0 got=%h want=01", kernel_flat[7:0]); end
        total++; if (kernel_flat[71:64] !== 8'h09) begin bad++; $display("FAIL coef8 got=%h want=09", kernel_flat[71:64]); end
        exp = sb_q.pop_front();
        total++; if (kernel_flat !== exp) begin bad++; $display("FAIL first_flat got=%h want=%h", kernel_flat, exp); end
        prev_k = exp;
        tick();
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", load_done); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ready_after_commit got=%b want=0", s_ready); end
    endtask

    task automatic test_early_last();
        pulse_start();
        for (int i = 0; i < 4; i++) beat(DW'(8'h50 + i), 1'b0);
        beat(8'h54, 1'b1);
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL early_err got=%b want=1", load_err); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL early_ready got=%b want=0", s_ready); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL early_done got=%b want=0", load_done); end
`ifdef KERNEL_LOADER_DBUF_EN
        total++; if (kernel_valid !== 1'b1) begin bad++; $display("FAIL early_valid got=%b want=1", kernel_valid); end
        total++; if (kernel_flat !== prev_k) begin bad++; $display("FAIL early_flat got=%h want=%h", kernel_flat, prev_k); end
`else
        total++; if (kernel_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b want=0", kernel_valid); end
`endif
        tick();
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", load_err); end
    endtask

    task automatic test_missing_last();
        pulse_start();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b want=0", load_err); end
        for (int i = 0; i < NC; i++) beat(DW'(8'h60 + i), 1'b0);
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL missing_err got=%b want=1", load_err); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL missing_done got=%b want=0", load_done); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL missing_ready got=%b want=0", s_ready); end
`ifdef KERNEL_LOADER_DBUF_EN
        total++; if (kernel_flat !== prev_k) begin bad++; $display("FAIL missing_flat got=%h want=%h", kernel_flat, prev_k); end
`else
        total++; if (kernel_valid !== 1'b0) begin bad++; $display("FAIL missing_valid got=%b want=0", kernel_valid); end
`endif
        pulse_start();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL restart_clears_err got=%b want=0", load_err); end
    endtask

    task automatic test_abort();
        logic [FW-1:0] exp;
        for (int i = 0; i < 3; i++) beat(DW'(8'hA0 + i), 1'b0);
        load_start = 1'b1; s_valid = 1'b1; s_data = 8'hA3; s_last = 1'b1;
        tick();
        load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        total++; if ({s_ready, load_err, load_done} !== 3'b100) begin
            bad++; $display("FAIL abort_state got=%b want=100", {s_ready, load_err, load_done}); end
        send_kernel(8'hF0);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b want=1", load_done); end
        total++; if (kernel_flat[7:0] !== 8'hF0) begin bad++; $display("FAIL abort_coef0 got=%h want=f0", kernel_flat[7:0]); end
        exp = sb_q.pop_front();
        total++; if (kernel_flat !== exp) begin bad++; $display("FAIL abort_flat got=%h want=%h", kernel_flat, exp); end
        prev_k = exp;
        tick();
    endtask

    task automatic test_dbuf_hold();
        logic [FW-1:0] e;
        logic [FW-1:0] exp;
        int gap;
        int hold_bad;
        e = '0;
        for (int i = 0; i < NC; i++) e[i*DW +: DW] = DW'($urandom);
        sb_q.push_back(e);
        hold_bad = 0;
        pulse_start();
        for (int i = 0; i < NC; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                s_last  = 1'b1;
                tick();
`ifdef KERNEL_LOADER_DBUF_EN
                total++; if (kernel_flat !== prev_k || kernel_valid !== 1'b1) begin
                    bad++; $display("FAIL hold_gap got=%h/%b want=%h/1", kernel_flat, kernel_valid, prev_k); end
`else
                total++; if (kernel_valid !== 1'b0) begin bad++; $display("FAIL hold_gap_valid got=%b want=0", kernel_valid); end
`endif
            end
            s_last = 1'b0;
            beat(e[i*DW +: DW], i == NC - 1);
            if (i < NC - 1) begin
`ifdef KERNEL_LOADER_DBUF_EN
                total++; if (kernel_flat !== prev_k || kernel_valid !== 1'b1) begin
                    bad++; $display("FAIL hold_beat got=%h/%b want=%h/1", kernel_flat, kernel_valid, prev_k); end
`else
                total++; if (kernel_valid !== 1'b0) begin bad++; $display("FAIL hold_beat_valid got=%b want=0", kernel_valid); end
`endif
                total++; if (load_done !== 1'b0) begin bad++; $display("FAIL hold_done_early got=%b want=0", load_done); end
            end
        end
        total++; if (load_done !== 1'b1 || kernel_valid !== 1'b1) begin
            bad++; $display("FAIL hold_commit got=%b/%b want=1/1", load_done, kernel_valid); end
        exp = sb_q.pop_front();
        total++; if (kernel_flat !== exp) begin bad++; $display("FAIL hold_switch got=%h want=%h", kernel_flat, exp); end
        prev_k = exp;
        tick();
    endtask

    task automatic test_reset_mid_load();
        logic [FW-1:0] exp;
        pulse_start();
        for (int i = 0; i < 6; i++) beat(DW'(8'h20 + i), 1'b0);
        #2 rst = 1'b1;
        #1;
        total++; if (kernel_flat !== '0) begin bad++; $display("FAIL midrst_flat got=%h want=0", kernel_flat); end
        total++; if ({kernel_valid, load_done, load_err, s_ready} !== 4'b0000) begin
            bad++; $display("FAIL midrst_flags got=%b want=0000", {kernel_valid, load_done, load_err, s_ready}); end
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send_kernel(8'h30);
        exp = sb_q.pop_front();
        total++; if (load_done !== 1'b1 || kernel_flat !== exp) begin
            bad++; $display("FAIL after_rst_commit got=%b/%h want=1/%h", load_done, kernel_flat, exp); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] exp;
        pulse_start();
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b want=0", load_done); end
        send_kernel(8'hC0);
        exp = sb_q.pop_front();
        total++; if (load_done !== 1'b1 || kernel_flat !== exp) begin
            bad++; $display("FAIL b2b_commit got=%b/%h want=1/%h", load_done, kernel_flat, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_early_last();
        test_missing_last();
        test_abort();
        test_dbuf_hold();
        test_reset_mid_load();
        test_back_to_back();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_loader.md
# kernel_loader

Write-side counterpart of the kernel coefficient store. It accepts a stream of signed 8-bit coefficients over a valid/ready interface, checks framing, and commits them into a KER_SIZE×KER_SIZE register bank in row-major order. It presents the bank as a flat bus with a `kernel_valid` flag, so the convolution datapath can load new kernels at run time instead of using an init-time memory image.

## Interface
- `KER_SIZE`, default 3: kernel edge length; N_COEF = KER_SIZE*KER_SIZE.
- `DATA_W`, default 8: coefficient width in bits.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: one-cycle pulse that begins a new kernel load.
- `s_valid` in 1: coefficient valid.
- `s_data` in DATA_W: coefficient value.
- `s_last` in 1: marks the final coefficient of a frame.
- `s_ready` out 1: loader accepts a coefficient.
- `kernel_flat` out N_COEF*DATA_W: committed kernel; coefficient i is at `[i*DATA_W +: DATA_W]`, with i = row*KER_SIZE + col.
- `kernel_valid` out 1: `kernel_flat` holds a complete committed kernel.
- `load_done` out 1: one-cycle pulse on commit.
- `load_err` out 1: sticky framing error; cleared by `load_start` or `rst`.

## Operation
- **States:** IDLE, LOAD.
  - IDLE → LOAD on `load_start`.
  - LOAD → IDLE on commit, on error, or on `rst`.
- **Handshake:**
  - `s_ready` = 1 only in LOAD.
  - A beat transfers when `s_valid && s_ready`.
  - `s_data` and `s_last` are ignored in IDLE.
- **Index counter:**
  - Width `$clog2(N_COEF)`.
  - Cleared on entry to LOAD.
  - Increments per accepted beat.
  - The beat at index i writes coefficient i.
- **Commit:** the beat at index N_COEF-1 with `s_last`=1 causes the following on the next edge:
  - bank committed;
  - `kernel_valid` ← 1;
  - `load_done` pulses;
  - state ← IDLE.
- **Framing errors:** two cases.
  - `s_last`=1 on index < N_COEF-1.
  - `s_last`=0 on index N_COEF-1.

  Either error causes:
  - `load_err` ← 1;
  - state ← IDLE;
  - no commit;
  - the beat is consumed.
- **`load_start` in LOAD:** aborts the load and restarts at index 0. If a beat transfers in the same cycle, it is discarded; the restart takes priority over a commit or an error.
- **`load_start` in IDLE:** clears `load_err`. `kernel_valid` is handled per Configuration.
- **Coefficient values:** stored verbatim; no arithmetic and no sign extension.

## Timing
- **Reset values:**
  - state IDLE;
  - index 0;
  - all bank bits 0;
  - `kernel_flat` 0;
  - `kernel_valid` 0;
  - `load_done` 0;
  - `load_err` 0;
  - `s_ready` 0.
- **Reset mid-load:** the load is discarded and all outputs go immediately to their reset values.
- **Ready timing:** `s_ready` rises the cycle after `load_start` is sampled.
- **Commit latency:** `kernel_valid` and the new `kernel_flat` appear 1 cycle after the final beat transfers.
- **Throughput:** a full load takes a minimum of N_COEF+1 cycles from `load_start` to `load_done`. Back-to-back beats are accepted.
- **`load_done`:** high for exactly one cycle per commit.
- **`load_err`:** set 1 cycle after the offending beat transfers.

## Configuration
- `KERNEL_LOADER_DBUF_EN` **defined:** the bank is double-buffered.
  - Beats write a shadow bank.
  - `kernel_flat` and `kernel_valid` hold the previous kernel for the whole load.
  - On commit, shadow → active in one cycle.
  - An error or abort leaves the active kernel and `kernel_valid` untouched.
- `KERNEL_LOADER_DBUF_EN` **undefined:** single bank.
  - `kernel_valid` ← 0 the cycle after `load_start`.
  - Beats write the active bank directly, so `kernel_flat` changes as beats arrive.
  - After an error or abort, `kernel_valid` stays 0 until the next successful commit.

## Structure
- **Package `kernel_pkg`:**
  - `KER_SIZE`, `DATA_W` and `N_COEF` constants;
  - the state enum `kl_state_t` {IDLE, LOAD}, shared with the kernel store.
- **Sub-module `kernel_bank`:**
  - N_COEF×DATA_W register array;
  - one write port (enable, index, data);
  - flat read bus.

  `kernel_loader` instantiates one `kernel_bank`, or two when `KERNEL_LOADER_DBUF_EN` is defined; the commit copy is the active bank's parallel load.

## Test plan
- **Reset:** assert `rst`. Required: all outputs 0. Then `load_start` followed by 9 beats of 0x01..0x09, with `s_last` on the 9th. Required: `kernel_flat[7:0]`=0x01 and `kernel_flat[71:64]`=0x09; `kernel_valid`=1 and `load_done` pulses 1 cycle after the 9th beat.
- **Early last:** `s_last` on the 5th beat. Required: `load_err`=1, `s_ready`=0 the next cycle, no `load_done`, `kernel_valid` unchanged (DBUF build).
- **Missing last:** 9th beat with `s_last`=0. Required: `load_err`=1, no commit. A following `load_start` clears `load_err`.
- **Abort:** `load_start` during the 4th beat, then 9 beats of 0xF0..0xF8. Required: coefficient 0 = 0xF0, no trace of the aborted data.
- **DBUF hold:** commit kernel A, then load kernel B with random `s_valid` gaps. Required: `kernel_flat` = A throughout the load and switches to B exactly 1 cycle after B's last beat. In the non-DBUF build, `kernel_valid`=0 during the load instead.
- **Reset mid-load:** `rst` after 6 beats. Required: all outputs 0 immediately; the next full load commits correctly.
